// File: rtl/buffered_demultiplexer_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 demultiplexer.
// Lane count, delivery counter width and its saturation ceiling live here.
package buffered_demultiplexer_pkg;

    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;

    typedef logic [LANES-1:0] lane_mask_t;
    typedef logic [1:0]       lane_idx_t;

    // Number of lanes set in a mask (0..4).
    function automatic logic [2:0] lane_popcount(input lane_mask_t mask);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            n = n + {2'b00, mask[i]};
        end
        return n;
    endfunction

    // Saturating add of a small increment onto the delivery counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {2'b00, inc};
        if (sum > {1'b0, CNT_SAT}) begin
            return CNT_SAT;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/buffered_demultiplexer_demux_lane.sv
// One-entry output buffer for a single demux lane: data register plus valid flag.
// A reload in the same cycle as a delivery keeps the lane valid with the new data.
module demux_lane
    import buffered_demultiplexer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Data register: captures din on load, otherwise holds the last loaded value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= din;
        end else begin
            data_r <= data_r;
        end
    end

    // Valid flag: load has priority over delivery; ack on an empty lane is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
        end else if (ack && valid_r) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/buffered_demultiplexer.sv
// Routes din to one of four buffered lanes (or all four on broadcast) with a
// ready/valid handshake per side and a saturating count of completed deliveries.
module buffered_demultiplexer
    import buffered_demultiplexer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             addr0,
    input  logic             addr1,
    input  logic [WIDTH-1:0] din,
    input  logic             broadcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [3:0]       deliver_count
);

    lane_idx_t        sel_s;
    lane_mask_t       free_s;
    lane_mask_t       load_s;
    lane_mask_t       deliver_s;
    lane_mask_t       valid_s;
    logic             ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] lane_data_s [LANES];
    logic [CNT_W-1:0] count_r;

    assign sel_s     = {addr1, addr0};
    assign free_s    = ~valid_s | out_ack;
    assign deliver_s = valid_s & out_ack;
    assign accept_s  = in_valid & ready_s;

    // Ready: a unicast needs only its target lane free, a broadcast needs all lanes.
    always_comb begin
        ready_s = 1'b0;
        if (broadcast) begin
            ready_s = &free_s;
        end else begin
            ready_s = free_s[sel_s];
        end
    end

    // Lane load enables derived from the accepted transfer.
    always_comb begin
        load_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (accept_s && (broadcast || (sel_s == 2'(i)))) begin
                load_s[i] = 1'b1;
            end else begin
                load_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        demux_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load_s[g]),
            .ack   (out_ack[g]),
            .din   (din),
            .data  (lane_data_s[g]),
            .valid (valid_s[g])
        );
    end

    // Delivery counter: adds every lane handing off data this cycle, clamps at the ceiling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= sat_add(count_r, lane_popcount(deliver_s));
        end
    end

    assign in_ready      = ready_s;
    assign out0          = lane_data_s[0];
    assign out1          = lane_data_s[1];
    assign out2          = lane_data_s[2];
    assign out3          = lane_data_s[3];
    assign out_valid     = valid_s;
    assign deliver_count = count_r;

endmodule

// File: tb/tb_buffered_demultiplexer.sv
// Directed self-checking bench for buffered_demultiplexer (WIDTH=1).
module tb_buffered_demultiplexer;

    logic       clk;
    logic       reset;
    logic       addr0;
    logic       addr1;
    logic [0:0] din;
    logic       broadcast;
    logic       in_valid;
    logic       in_ready;
    logic [0:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ack;
    logic [3:0] deliver_count;
    logic [3:0] outs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    buffered_demultiplexer #(.WIDTH(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .addr0         (addr0),
        .addr1         (addr1),
        .din           (din),
        .broadcast     (broadcast),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out0          (out0),
        .out1          (out1),
        .out2          (out2),
        .out3          (out3),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .deliver_count (deliver_count)
    );

    assign outs = {out3, out2, out1, out0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid  = 1'b0;
        broadcast = 1'b0;
        out_ack   = 4'b0000;
        addr0     = 1'b0;
        addr1     = 1'b0;
        din       = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Offer din to lane a at the next negedge, keep it through one rising edge.
    task automatic offer(input logic [1:0] a, input logic d, input logic [3:0] ack);
        @(negedge clk);
        {addr1, addr0} = a;
        din      = d;
        in_valid = 1'b1;
        out_ack  = ack;
        broadcast = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 4'b0000) $display("FAIL reset_valid got %b exp 0000", out_valid); else pass_cnt++;
        total_cnt++; if (outs !== 4'b0000) $display("FAIL reset_data got %b exp 0000", outs); else pass_cnt++;
        total_cnt++; if (deliver_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", deliver_count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_address_routing();
        logic [3:0] exp_v;
        for (int a = 0; a < 4; a++) begin
            pulse_reset();
            offer(2'(a), 1'b1, 4'b0000);
            step();
            exp_v = 4'b0001 << a;
            total_cnt++; if (out_valid !== exp_v) $display("FAIL route%0d_valid got %b exp %b", a, out_valid, exp_v); else pass_cnt++;
            total_cnt++; if (outs !== exp_v) $display("FAIL route%0d_data got %b exp %b", a, outs, exp_v); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        offer(2'd2, 1'b1, 4'b0000);
        step();
        offer(2'd2, 1'b0, 4'b0000);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready got %b exp 0", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (out2 !== 1'b1) $display("FAIL bp_hold_data got %b exp 1", out2); else pass_cnt++;
        total_cnt++; if (out_valid !== 4'b0100) $display("FAIL bp_hold_valid got %b exp 0100", out_valid); else pass_cnt++;
        offer(2'd1, 1'b1, 4'b0000);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_other_ready got %b exp 1", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 4'b0110) $display("FAIL bp_other_valid got %b exp 0110", out_valid); else pass_cnt++;
        total_cnt++; if (outs !== 4'b0110) $display("FAIL bp_other_data got %b exp 0110", outs); else pass_cnt++;
        // Ack on an empty lane must not count.
        @(negedge clk);
        out_ack = 4'b1001;
        step();
        total_cnt++; if (deliver_count !== 4'd0) $display("FAIL ack_empty_count got %0d exp 0", deliver_count); else pass_cnt++;
    endtask

    task automatic test_reload();
        pulse_reset();
        offer(2'd0, 1'b1, 4'b0000);
        step();
        offer(2'd0, 1'b0, 4'b0001);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reload_ready got %b exp 1", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 4'b0001) $display("FAIL reload_valid got %b exp 0001", out_valid); else pass_cnt++;
        total_cnt++; if (out0 !== 1'b0) $display("FAIL reload_data got %b exp 0", out0); else pass_cnt++;
        total_cnt++; if (deliver_count !== 4'd1) $display("FAIL reload_count got %0d exp 1", deliver_count); else pass_cnt++;
        // Plain delivery: valid clears, data held.
        @(negedge clk);
        out_ack = 4'b0001;
        step();
        total_cnt++; if (out_valid !== 4'b0000) $display("FAIL deliver_valid got %b exp 0000", out_valid); else pass_cnt++;
        total_cnt++; if (deliver_count !== 4'd2) $display("FAIL deliver_count got %0d exp 2", deliver_count); else pass_cnt++;
    endtask

    task automatic test_broadcast();
        pulse_reset();
        offer(2'd3, 1'b0, 4'b0000);
        step();
        @(negedge clk);
        broadcast = 1'b1;
        din       = 1'b1;
        in_valid  = 1'b1;
        {addr1, addr0} = 2'b00;
        out_ack   = 4'b0000;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bcast_blocked got %b exp 0", in_ready); else pass_cnt++;
        out_ack = 4'b1000;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bcast_ready got %b exp 1", in_ready); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 4'b1111) $display("FAIL bcast_valid got %b exp 1111", out_valid); else pass_cnt++;
        total_cnt++; if (outs !== 4'b1111) $display("FAIL bcast_data got %b exp 1111", outs); else pass_cnt++;
        total_cnt++; if (deliver_count !== 4'd1) $display("FAIL bcast_count got %0d exp 1", deliver_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int exp_cnt;
        pulse_reset();
        exp_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            offer(2'd0, 1'(k), 4'b0001);
            #1;
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready cycle %0d got %b exp 1", k, in_ready); else pass_cnt++;
            step();
            if (k > 1) exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            total_cnt++; if (deliver_count !== 4'(exp_cnt)) $display("FAIL b2b_count cycle %0d got %0d exp %0d", k, deliver_count, exp_cnt); else pass_cnt++;
        end
        total_cnt++; if (deliver_count !== 4'd15) $display("FAIL b2b_saturate got %0d exp 15", deliver_count); else pass_cnt++;
        total_cnt++; if (out_valid !== 4'b0001) $display("FAIL b2b_valid got %b exp 0001", out_valid); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        // Lanes 0 and 1 loaded, counter at 15 from the previous scenario.
        offer(2'd1, 1'b1, 4'b0000);
        step();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 4'b0000) $display("FAIL arst_valid got %b exp 0000", out_valid); else pass_cnt++;
        total_cnt++; if (outs !== 4'b0000) $display("FAIL arst_data got %b exp 0000", outs); else pass_cnt++;
        total_cnt++; if (deliver_count !== 4'd0) $display("FAIL arst_count got %0d exp 0", deliver_count); else pass_cnt++;
        // Traffic during reset must have no effect.
        in_valid  = 1'b1;
        broadcast = 1'b1;
        din       = 1'b1;
        out_ack   = 4'b1111;
        @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 4'b0000) $display("FAIL arst_ignore_valid got %b exp 0000", out_valid); else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        offer(2'd3, 1'b1, 4'b0000);
        step();
        total_cnt++; if (out_valid !== 4'b1000) $display("FAIL post_rst_valid got %b exp 1000", out_valid); else pass_cnt++;
        total_cnt++; if (outs !== 4'b1000) $display("FAIL post_rst_data got %b exp 1000", outs); else pass_cnt++;
        total_cnt++; if (deliver_count !== 4'd0) $display("FAIL post_rst_count got %0d exp 0", deliver_count); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_address_routing();
        test_backpressure();
        test_reload();
        test_broadcast();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/buffered_demultiplexer.md
BUFFERED_DEMULTIPLEXER -- requirements
Module: buffered_demultiplexer

Interface
REQ-001 Parameter WIDTH, default 1, data width of din and of each lane output.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr0  input  1  lane select LSB.
REQ-006 addr1  input  1  lane select MSB; lane index = {addr1,addr0}.
REQ-007 din  input  WIDTH  data to route.
REQ-008 broadcast  input  1  1 = route din to all four lanes; address ignored.
REQ-009 in_valid  input  1  producer offers din this cycle.
REQ-010 in_ready  output  1  block accepts din this cycle (combinational).
REQ-011 out0..out3  output  WIDTH each  lane data registers.
REQ-012 out_valid  output  4  bit i = lane i holds undelivered data.
REQ-013 out_ack  input  4  bit i = consumer of lane i takes data this cycle.
REQ-014 deliver_count  output  4  saturating count of completed lane deliveries.

Function
REQ-015 Each lane SHALL be a one-entry buffer: data register plus valid flag.
REQ-016 Lane i SHALL be "free" in a cycle when out_valid[i]=0 or out_ack[i]=1.
REQ-017 in_ready SHALL be: broadcast=0 -> selected lane free; broadcast=1 -> all four lanes free.
REQ-018 Accept SHALL occur when in_valid=1 and in_ready=1; target lane(s) load din and set valid at that rising edge (latency 1 cycle to out_valid).
REQ-019 When in_valid=1 and in_ready=0, no state SHALL change; the producer holds din, addr, broadcast stable.
REQ-020 Delivery on lane i SHALL occur when out_valid[i]=1 and out_ack[i]=1; valid clears at the edge unless the lane is reloaded.
REQ-021 Simultaneous delivery and reload on the same lane SHALL leave valid=1 with the new data (reload wins).
REQ-022 out_ack[i] with out_valid[i]=0 SHALL be ignored.
REQ-023 outN SHALL hold its last loaded value after delivery until reloaded.
REQ-024 Non-target lanes SHALL be unaffected by an accept.
REQ-025 deliver_count SHALL add the number of lanes delivering this cycle (0-4) and saturate at 15; no wrap.
REQ-026 Full throughput: one accept per cycle to a lane whose consumer acks every cycle.

Reset
REQ-027 Assertion of reset SHALL immediately clear out_valid to 0, out0..out3 to 0, deliver_count to 0, regardless of clk.
REQ-028 During reset, in_valid and out_ack SHALL be ignored; in_ready MAY read 1 but no accept takes effect.
REQ-029 Reset mid-operation SHALL discard all buffered data; first accept after deassertion behaves as from power-up.

Structure
REQ-030 A shared package SHALL hold the lane-count constant (4), the count width (4), and the count saturation value (15).
REQ-031 One sub-module demux_lane (one-entry buffer: load, ack, data, valid) SHALL be instantiated four times; routing, in_ready, and counter live in the top.

Verification
REQ-032 Post-reset: out_valid=0000, all outN=0, deliver_count=0, in_ready=1.
REQ-033 For each address 00,01,10,11 with din=1, no ack: exactly lane {addr1,addr0} valid one cycle later with data 1; others remain 0.
REQ-034 Lane 2 full, no ack, second offer to addr 10 -> in_ready=0, data unchanged; offer to addr 01 -> accepted.
REQ-035 Lane 0 full, out_ack[0]=1 and new din=0 to addr 00 same cycle -> out_valid[0] stays 1, out0=0, deliver_count +1.
REQ-036 broadcast=1 with lane 3 full and unacked -> in_ready=0; ack lane 3 same cycle -> all four lanes loaded, count +1.
REQ-037 20 back-to-back deliveries -> deliver_count reaches 15 and holds; async reset mid-stream -> all outputs 0 before next clk edge.
